// File: rtl/multicycle_control_if.sv
// Memory handshake between the multicycle control FSM and the unified
// instruction/data memory: request strobes and address select out, ready back.
interface multicycle_control_if;
  logic MemRead;
  logic MemWrite;
  logic IorD;
  logic MemReady;

  modport master (output MemRead, output MemWrite, output IorD, input MemReady);
  modport slave  (input MemRead, input MemWrite, input IorD, output MemReady);
endinterface

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle mini CPU (fetch/decode/execute/memory/writeback).
// Optional retired-instruction counter enabled by defining INSTR_COUNT_EN.
module multicycle_control #(
  parameter int WAIT_LIMIT = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  multicycle_control_if.master mem,
  input  logic [5:0]           opcode,
  input  logic                 Zero,
  output logic                 PCWrite,
  output logic                 PCWriteCond,
  output logic                 IRWrite,
  output logic                 MemtoReg,
  output logic                 RegDst,
  output logic                 RegWrite,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ALUOP,
  output logic [1:0]           PCSource,
  output logic                 Halted,
  output logic                 BusError,
  output logic [3:0]           State
`ifdef INSTR_COUNT_EN
  ,
  output logic [31:0]          InstrCount
`endif
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_ALU_WB   = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_MEM_WB   = 4'd7,
    S_MEM_WR   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_HALT     = 4'd11,
    S_ERROR    = 4'd12
  } state_t;

  localparam logic [7:0] LIMIT_C = 8'(WAIT_LIMIT);

  state_t     state_r;
  state_t     next_s;
  logic [7:0] wait_cnt_r;
  logic       is_sw_r;
  logic       mem_state_s;
  logic       limit_hit_s;
  logic       op_rtype_s;
  logic       op_lw_s;
  logic       op_sw_s;
  logic       op_beq_s;
  logic       op_j_s;
  logic       op_halt_s;
  logic       unused_zero_s;

  // Zero qualifies the PC load inside the datapath; the FSM only raises PCWriteCond
  assign unused_zero_s = Zero;

  assign op_rtype_s  = (opcode[5:4] == 2'b00);
  assign op_lw_s     = (opcode == 6'b010000);
  assign op_sw_s     = (opcode == 6'b010001);
  assign op_beq_s    = (opcode == 6'b010010);
  assign op_j_s      = (opcode == 6'b010011);
  assign op_halt_s   = (opcode == 6'b111111);

  assign mem_state_s = (state_r == S_FETCH) || (state_r == S_MEM_RD) || (state_r == S_MEM_WR);
  assign limit_hit_s = (wait_cnt_r == LIMIT_C);
  assign State       = state_r;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Load/store direction is captured in DECODE so MEM_ADDR ignores a changed opcode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_sw_r <= 1'b0;
    end else if (state_r == S_DECODE) begin
      is_sw_r <= op_sw_s;
    end else begin
      is_sw_r <= is_sw_r;
    end
  end

  // Wait counter: counts stalled cycles in a memory state, zero everywhere else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_r <= 8'd0;
    end else if (mem_state_s && !mem.MemReady) begin
      wait_cnt_r <= wait_cnt_r + 8'd1;
    end else begin
      wait_cnt_r <= 8'd0;
    end
  end

  // Next-state and control decode; IRWrite/PCWrite in FETCH follow MemReady
  always_comb begin
    next_s       = state_r;
    PCWrite      = 1'b0;
    PCWriteCond  = 1'b0;
    IRWrite      = 1'b0;
    MemtoReg     = 1'b0;
    RegDst       = 1'b0;
    RegWrite     = 1'b0;
    ALUSrcA      = 1'b0;
    ALUSrcB      = 2'b00;
    ALUOP        = 2'b00;
    PCSource     = 2'b00;
    Halted       = 1'b0;
    BusError     = 1'b0;
    mem.MemRead  = 1'b0;
    mem.MemWrite = 1'b0;
    mem.IorD     = 1'b0;
    case (state_r)
      S_IDLE: next_s = S_FETCH;
      S_FETCH: begin
        mem.MemRead = 1'b1;
        ALUSrcB     = 2'b01;
        if (mem.MemReady) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          next_s  = S_DECODE;
        end else if (limit_hit_s) begin
          next_s = S_ERROR;
        end else begin
          next_s = S_FETCH;
        end
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        if (op_rtype_s) begin
          next_s = S_EXEC_R;
        end else if (op_lw_s || op_sw_s) begin
          next_s = S_MEM_ADDR;
        end else if (op_beq_s) begin
          next_s = S_BRANCH;
        end else if (op_j_s) begin
          next_s = S_JUMP;
        end else if (op_halt_s) begin
          next_s = S_HALT;
        end else begin
          next_s = S_FETCH;
        end
      end
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUOP   = 2'b10;
        next_s  = S_ALU_WB;
      end
      S_ALU_WB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
        next_s   = S_FETCH;
      end
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        if (is_sw_r) begin
          next_s = S_MEM_WR;
        end else begin
          next_s = S_MEM_RD;
        end
      end
      S_MEM_RD, S_MEM_WR: begin
        mem.IorD     = 1'b1;
        mem.MemRead  = (state_r == S_MEM_RD);
        mem.MemWrite = (state_r == S_MEM_WR);
        if (mem.MemReady) begin
          next_s = (state_r == S_MEM_RD) ? S_MEM_WB : S_FETCH;
        end else if (limit_hit_s) begin
          next_s = S_ERROR;
        end else begin
          next_s = state_r;
        end
      end
      S_MEM_WB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        next_s   = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOP       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        next_s      = S_FETCH;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        next_s   = S_FETCH;
      end
      S_HALT: begin
        Halted = 1'b1;
        next_s = S_HALT;
      end
      S_ERROR: begin
        BusError = 1'b1;
        next_s   = S_ERROR;
      end
      default: next_s = S_IDLE;
    endcase
  end

`ifdef INSTR_COUNT_EN
  logic [31:0] instr_cnt_r;
  logic        retire_s;

  // Any return to FETCH other than a fetch stall or the first fetch retires an instruction
  assign retire_s   = (next_s == S_FETCH) && (state_r != S_FETCH) && (state_r != S_IDLE);
  assign InstrCount = instr_cnt_r;

  // Retired-instruction counter, wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_cnt_r <= 32'd0;
    end else if (retire_s) begin
      instr_cnt_r <= instr_cnt_r + 32'd1;
    end else begin
      instr_cnt_r <= instr_cnt_r;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed scenarios plus a random
// instruction stream checked against a per-instruction state-sequence model.
module tb_multicycle_control;
  localparam int LIMIT = 4;
  localparam int ST_IDLE = 0, ST_FETCH = 1, ST_DECODE = 2, ST_EXEC_R = 3, ST_ALU_WB = 4;
  localparam int ST_MEM_ADDR = 5, ST_MEM_RD = 6, ST_MEM_WB = 7, ST_MEM_WR = 8;
  localparam int ST_BRANCH = 9, ST_JUMP = 10, ST_HALT = 11, ST_ERROR = 12;

  typedef struct {
    int         st;
    logic       mr;
    logic [5:0] op;
  } step_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic       Zero;
  logic       PCWrite, PCWriteCond, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOP, PCSource;
  logic       Halted, BusError;
  logic [3:0] State;
`ifdef INSTR_COUNT_EN
  logic [31:0] InstrCount;
`endif
  int checks = 0;
  int failures = 0;

  multicycle_control_if bus();

  multicycle_control #(.WAIT_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n), .mem(bus), .opcode(opcode), .Zero(Zero),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOP(ALUOP), .PCSource(PCSource), .Halted(Halted),
    .BusError(BusError), .State(State)
`ifdef INSTR_COUNT_EN
    , .InstrCount(InstrCount)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [17:0] act_out();
    return {PCWrite, PCWriteCond, bus.IorD, bus.MemRead, bus.MemWrite, IRWrite, MemtoReg,
            RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOP, PCSource, Halted, BusError};
  endfunction

  // Expected control word for a state, straight from the control table
  function automatic logic [17:0] exp_out(input int st, input logic mr);
    logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, hal, berr;
    logic [1:0] srcb, aluop, pcs;
    {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, hal, berr} = 12'd0;
    {srcb, aluop, pcs} = 6'd0;
    case (st)
      ST_FETCH:    begin mrd = 1'b1; srcb = 2'b01; irw = mr; pcw = mr; end
      ST_DECODE:   srcb = 2'b11;
      ST_EXEC_R:   begin srca = 1'b1; aluop = 2'b10; end
      ST_ALU_WB:   begin rw = 1'b1; rdst = 1'b1; end
      ST_MEM_ADDR: begin srca = 1'b1; srcb = 2'b10; end
      ST_MEM_RD:   begin mrd = 1'b1; iord = 1'b1; end
      ST_MEM_WB:   begin rw = 1'b1; m2r = 1'b1; end
      ST_MEM_WR:   begin mwr = 1'b1; iord = 1'b1; end
      ST_BRANCH:   begin srca = 1'b1; aluop = 2'b01; pcwc = 1'b1; pcs = 2'b01; end
      ST_JUMP:     begin pcw = 1'b1; pcs = 2'b10; end
      ST_HALT:     hal = 1'b1;
      ST_ERROR:    berr = 1'b1;
      default:     ;
    endcase
    return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, srcb, aluop, pcs, hal, berr};
  endfunction

  function automatic step_t mk(input int st, input logic mr, input logic [5:0] op);
    step_t s;
    s.st = st;
    s.mr = mr;
    s.op = op;
    return s;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    bus.MemReady = 1'b0;
    opcode = 6'd0;
    Zero = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic tick(input logic mr, input logic [5:0] op, input logic z);
    @(negedge clk);
    bus.MemReady = mr;
    opcode = op;
    Zero = z;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if (State !== 4'd0 || act_out() !== 18'd0) begin
      failures++;
      $display("FAIL reset_hold: state=%0d outputs=%b required state=0 outputs=0", State, act_out());
    end
    do_reset();
    #1;
    checks++;
    if (State !== 4'd0 || act_out() !== 18'd0) begin
      failures++;
      $display("FAIL reset_idle: state=%0d outputs=%b required state=0 outputs=0", State, act_out());
    end
`ifdef INSTR_COUNT_EN
    checks++;
    if (InstrCount !== 32'd0) begin
      failures++;
      $display("FAIL reset_count: InstrCount=%0d required 0", InstrCount);
    end
`endif
  endtask

  task automatic test_rtype();
    int sts [5] = '{ST_FETCH, ST_DECODE, ST_EXEC_R, ST_ALU_WB, ST_FETCH};
    for (int i = 0; i < 5; i++) begin
      tick(1'b1, 6'b000010, 1'b0);
      checks++;
      if (int'(State) !== sts[i] || act_out() !== exp_out(sts[i], 1'b1)) begin
        failures++;
        $display("FAIL rtype[%0d]: state=%0d outputs=%b required state=%0d outputs=%b",
                 i, State, act_out(), sts[i], exp_out(sts[i], 1'b1));
      end
    end
  endtask

  task automatic test_lw_wait();
    int   sts [9] = '{ST_FETCH, ST_DECODE, ST_MEM_ADDR, ST_MEM_RD, ST_MEM_RD, ST_MEM_RD,
                      ST_MEM_RD, ST_MEM_WB, ST_FETCH};
    logic mrs [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      tick(mrs[i], 6'b010000, 1'b0);
      checks++;
      if (int'(State) !== sts[i] || act_out() !== exp_out(sts[i], mrs[i])) begin
        failures++;
        $display("FAIL lw_wait[%0d]: state=%0d outputs=%b required state=%0d outputs=%b",
                 i, State, act_out(), sts[i], exp_out(sts[i], mrs[i]));
      end
    end
  endtask

  task automatic test_beq();
    int sts [4] = '{ST_FETCH, ST_DECODE, ST_BRANCH, ST_FETCH};
    for (int z = 0; z < 2; z++) begin
      do_reset();
      for (int i = 0; i < 4; i++) begin
        tick(1'b1, 6'b010010, 1'(z));
        checks++;
        if (int'(State) !== sts[i] || act_out() !== exp_out(sts[i], 1'b1)) begin
          failures++;
          $display("FAIL beq_z%0d[%0d]: state=%0d outputs=%b required state=%0d outputs=%b",
                   z, i, State, act_out(), sts[i], exp_out(sts[i], 1'b1));
        end
      end
    end
  endtask

  task automatic test_timeout();
    int   exp_st;
    logic mr;
    do_reset();
    // LIMIT+1 stalled fetch cycles, then ERROR for good
    for (int i = 0; i < LIMIT + 7; i++) begin
      mr = (i > LIMIT) ? 1'($urandom) : 1'b0;
      exp_st = (i <= LIMIT) ? ST_FETCH : ST_ERROR;
      tick(mr, 6'b000000, 1'b0);
      checks++;
      if (int'(State) !== exp_st || act_out() !== exp_out(exp_st, mr)) begin
        failures++;
        $display("FAIL timeout[%0d]: state=%0d outputs=%b required state=%0d outputs=%b",
                 i, State, act_out(), exp_st, exp_out(exp_st, mr));
      end
    end
    do_reset();
    // MemReady arrives exactly on the limit cycle: no error
    for (int i = 0; i < LIMIT + 2; i++) begin
      mr = (i >= LIMIT) ? 1'b1 : 1'b0;
      exp_st = (i <= LIMIT) ? ST_FETCH : ST_DECODE;
      tick(mr, 6'b000000, 1'b0);
      checks++;
      if (int'(State) !== exp_st || act_out() !== exp_out(exp_st, mr)) begin
        failures++;
        $display("FAIL limit_ready[%0d]: state=%0d outputs=%b required state=%0d outputs=%b",
                 i, State, act_out(), exp_st, exp_out(exp_st, mr));
      end
    end
  endtask

  task automatic test_halt_illegal();
    int   exp_st;
    logic mr;
    do_reset();
    for (int i = 0; i < 22; i++) begin
      exp_st = (i == 0) ? ST_FETCH : (i == 1) ? ST_DECODE : ST_HALT;
      mr = (i < 2) ? 1'b1 : 1'($urandom);
      tick(mr, (i < 2) ? 6'b111111 : 6'($urandom), 1'($urandom));
      checks++;
      if (int'(State) !== exp_st || act_out() !== exp_out(exp_st, mr)) begin
        failures++;
        $display("FAIL halt[%0d]: state=%0d outputs=%b required state=%0d outputs=%b",
                 i, State, act_out(), exp_st, exp_out(exp_st, mr));
      end
    end
    do_reset();
    for (int i = 0; i < 4; i++) begin
      exp_st = (i == 1 || i == 3) ? ST_DECODE : ST_FETCH;
      tick(1'b1, 6'b100000, 1'b0);
      checks++;
      if (int'(State) !== exp_st || RegWrite !== 1'b0 || bus.MemWrite !== 1'b0) begin
        failures++;
        $display("FAIL illegal[%0d]: state=%0d RegWrite=%b MemWrite=%b required state=%0d 0 0",
                 i, State, RegWrite, bus.MemWrite, exp_st);
      end
    end
  endtask

  task automatic test_random();
    step_t      q[$];
    int         cls, fw, mw, n_instr;
    logic [5:0] op;
    n_instr = 40;
    do_reset();
    for (int k = 0; k < n_instr; k++) begin
      cls = int'($urandom_range(0, 5));
      fw  = int'($urandom_range(0, LIMIT));
      mw  = int'($urandom_range(0, LIMIT));
      case (cls)
        0:       op = {2'b00, 4'($urandom)};
        1:       op = 6'b010000;
        2:       op = 6'b010001;
        3:       op = 6'b010010;
        4:       op = 6'b010011;
        default: op = {2'b10, 4'($urandom)};
      endcase
      for (int j = 0; j < fw; j++) q.push_back(mk(ST_FETCH, 1'b0, op));
      q.push_back(mk(ST_FETCH, 1'b1, op));
      q.push_back(mk(ST_DECODE, 1'($urandom), op));
      // after DECODE the opcode bus carries junk; the FSM must not care
      case (cls)
        0: begin
          q.push_back(mk(ST_EXEC_R, 1'($urandom), 6'($urandom)));
          q.push_back(mk(ST_ALU_WB, 1'($urandom), 6'($urandom)));
        end
        1, 2: begin
          q.push_back(mk(ST_MEM_ADDR, 1'($urandom), 6'($urandom)));
          for (int j = 0; j < mw; j++)
            q.push_back(mk((cls == 1) ? ST_MEM_RD : ST_MEM_WR, 1'b0, 6'($urandom)));
          q.push_back(mk((cls == 1) ? ST_MEM_RD : ST_MEM_WR, 1'b1, 6'($urandom)));
          if (cls == 1) q.push_back(mk(ST_MEM_WB, 1'($urandom), 6'($urandom)));
        end
        3: q.push_back(mk(ST_BRANCH, 1'($urandom), 6'($urandom)));
        4: q.push_back(mk(ST_JUMP, 1'($urandom), 6'($urandom)));
        default: ;
      endcase
    end
    q.push_back(mk(ST_FETCH, 1'b0, 6'd0));
    for (int i = 0; i < q.size(); i++) begin
      tick(q[i].mr, q[i].op, 1'($urandom));
      checks++;
      if (int'(State) !== q[i].st || act_out() !== exp_out(q[i].st, q[i].mr)) begin
        failures++;
        $display("FAIL random[%0d]: state=%0d outputs=%b required state=%0d outputs=%b",
                 i, State, act_out(), q[i].st, exp_out(q[i].st, q[i].mr));
      end
    end
`ifdef INSTR_COUNT_EN
    checks++;
    if (InstrCount !== 32'(n_instr)) begin
      failures++;
      $display("FAIL random_count: InstrCount=%0d required %0d", InstrCount, n_instr);
    end
`endif
  endtask

  task automatic test_async_reset();
    int sts [16] = '{ST_FETCH, ST_DECODE, ST_EXEC_R, ST_ALU_WB, ST_FETCH, ST_DECODE, ST_EXEC_R,
                     ST_ALU_WB, ST_FETCH, ST_DECODE, ST_EXEC_R, ST_ALU_WB,
                     ST_FETCH, ST_DECODE, ST_MEM_ADDR, ST_MEM_WR};
    do_reset();
    for (int i = 0; i < 16; i++) begin
      tick((i == 15) ? 1'b0 : 1'b1, (i < 12) ? 6'b000101 : 6'b010001, 1'b0);
      checks++;
      if (int'(State) !== sts[i]) begin
        failures++;
        $display("FAIL async_seq[%0d]: state=%0d required %0d", i, State, sts[i]);
      end
    end
    checks++;
    if (bus.MemWrite !== 1'b1) begin
      failures++;
      $display("FAIL async_memwrite: MemWrite=%b required 1", bus.MemWrite);
    end
`ifdef INSTR_COUNT_EN
    checks++;
    if (InstrCount !== 32'd3) begin
      failures++;
      $display("FAIL async_count3: InstrCount=%0d required 3", InstrCount);
    end
`endif
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (State !== 4'd0 || act_out() !== 18'd0) begin
      failures++;
      $display("FAIL async_reset: state=%0d outputs=%b required state=0 outputs=0", State, act_out());
    end
`ifdef INSTR_COUNT_EN
    checks++;
    if (InstrCount !== 32'd0) begin
      failures++;
      $display("FAIL async_count0: InstrCount=%0d required 0", InstrCount);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_wait();
    test_beq();
    test_timeout();
    test_halt_illegal();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM of the multicycle mini CPU. It sits directly upstream of the ALU control decoder and drives its 2-bit ALUOP.
- Sequences fetch, decode, execute, memory and writeback for each instruction.
- Drives datapath mux selects and write enables.
- Stalls on a ready handshake with the unified instruction/data memory.

Parameters:
- WAIT_LIMIT, 15: maximum consecutive memory wait cycles allowed before a bus error; legal range 1..255.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  6  IR[31:26]; sampled in DECODE.
- Zero  in  1  ALU zero flag.
- MemReady  in  1  memory has completed the current access.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  PC load if Zero.
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- IRWrite  out  1  instruction register load.
- MemtoReg  out  1  register write data select: 1 = MDR.
- RegDst  out  1  destination register select: 1 = rd, 0 = rt.
- RegWrite  out  1  register file write.
- ALUSrcA  out  1  ALU A input: 0 = PC, 1 = A register.
- ALUSrcB  out  2  ALU B input: 00 = B, 01 = const 4, 10 = sign-extended imm, 11 = sign-extended imm << 2.
- ALUOP  out  2  to the ALU control decoder: 00 = add, 01 = sub, 10 = funct from opcode[3:0].
- PCSource  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- Halted  out  1  sticky; CPU has halted.
- BusError  out  1  sticky; memory wait timeout occurred.
- State  out  4  current state encoding, for debug.

Behaviour:
- Reset: state = IDLE, all outputs 0, wait counter = 0. Reset is asynchronous and may assert mid-instruction; it aborts the instruction immediately.
- Opcode classes:
  - 00xxxx = R-type ALU
  - 010000 = LW
  - 010001 = SW
  - 010010 = BEQ
  - 010011 = J
  - 111111 = HALT
  - all others = illegal
- State encodings:
  - IDLE = 0, FETCH = 1, DECODE = 2, EXEC_R = 3, ALU_WB = 4, MEM_ADDR = 5, MEM_RD = 6, MEM_WB = 7, MEM_WR = 8, BRANCH = 9, JUMP = 10, HALT = 11, ERROR = 12.
- IDLE: all outputs 0; goes to FETCH on the next edge.
- FETCH:
  - Asserts MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOP=00, PCSource=00.
  - IRWrite and PCWrite are asserted only in the cycle where MemReady=1. These are the Mealy outputs; all other outputs are Moore.
  - On MemReady go to DECODE; otherwise stay.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOP=00 (branch target into ALUOut). Next state by class:
  - R-type → EXEC_R
  - LW or SW → MEM_ADDR
  - BEQ → BRANCH
  - J → JUMP
  - HALT → HALT
  - illegal → FETCH (treated as NOP)
- EXEC_R: ALUSrcA=1, ALUSrcB=00, ALUOP=10 → ALU_WB.
- ALU_WB: RegWrite=1, RegDst=1, MemtoReg=0 → FETCH.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOP=00 → MEM_RD for LW, MEM_WR for SW. Decode is latched in DECODE; opcode is not re-sampled.
- MEM_RD: MemRead=1, IorD=1; on MemReady → MEM_WB.
- MEM_WB: RegWrite=1, RegDst=0, MemtoReg=1 → FETCH.
- MEM_WR: MemWrite=1, IorD=1; on MemReady → FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOP=01, PCWriteCond=1, PCSource=01 → FETCH. The PC loads only if Zero=1.
- JUMP: PCWrite=1, PCSource=10 → FETCH.
- HALT: Halted=1, all other outputs 0; stays until reset.
- ERROR: BusError=1, all other outputs 0; stays until reset.
- Wait counter (8-bit):
  - Cleared on entry to FETCH, MEM_RD and MEM_WR, and in every cycle where MemReady=1.
  - Increments each cycle in one of those states with MemReady=0.
  - When the counter equals WAIT_LIMIT and MemReady=0, go to ERROR.
  - If MemReady=1 in the same cycle the limit is reached, MemReady wins and there is no error.
- MemRead and MemWrite are never asserted together. MemReady is ignored outside the three memory states.

Optional Feature:
- Macro: INSTR_COUNT_EN.
- When defined:
  - Adds output InstrCount, 32 bits.
  - Increments on every transition into FETCH from ALU_WB, MEM_WB, MEM_WR, BRANCH or JUMP, and from DECODE for illegal opcodes.
  - Wraps from 0xFFFFFFFF to 0. Reset value 0. Frozen in HALT and ERROR.
- When undefined: no port and no counter logic; all other behaviour is identical.

Test Plan:
- Reset and R-type: release rst_n, opcode=000010, MemReady=1 always → State sequence 0,1,2,3,4,1; ALUOP=10 in EXEC_R; RegWrite=1 and RegDst=1 in ALU_WB; IRWrite=PCWrite=1 in FETCH.
- LW with 3 wait cycles: opcode=010000, MemReady low 3 cycles in MEM_RD → MEM_RD held 4 cycles with MemRead=1 and IorD=1, then MEM_WB with MemtoReg=1 and RegWrite=1.
- BEQ: opcode=010010, Zero=1 → BRANCH asserts ALUOP=01, PCWriteCond=1, PCSource=01, then FETCH. Repeat with Zero=0 → same control outputs.
- Timeout: WAIT_LIMIT=4, MemReady=0 held in FETCH → ERROR entered on the 5th cycle, BusError=1 sticky. A variant with MemReady=1 on the limit cycle → DECODE and no error.
- HALT and illegal: opcode=111111 → Halted=1, outputs 0 for 20 cycles until rst_n falls. Opcode=100000 → DECODE then FETCH, with no RegWrite and no MemWrite.
- Async reset mid-MEM_WR: pull rst_n low while MemWrite=1 → all outputs 0 immediately, without waiting for a clock edge. With INSTR_COUNT_EN defined, InstrCount=3 after three completed instructions and returns to 0 on reset.
